// File: rtl/modaddsub_if.sv
// Handshake bundle for modaddsub_pipe: request side (in_*) and response side (out_*).
// The slave modport is the arithmetic unit. The master modport is whoever feeds it and drains it.
interface modaddsub_if #(
    parameter int LANES = 4,
    parameter int LOGQ  = 64,
    parameter int LOGQH = 47,
    parameter int TAGW  = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_op;
    logic [LANES*LOGQ-1:0]   in_a;
    logic [LANES*LOGQ-1:0]   in_b;
    logic [LOGQH-1:0]        in_qh;
    logic [TAGW-1:0]         in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*LOGQ-1:0]   out_c;
    logic [TAGW-1:0]         out_tag;
    logic [LANES-1:0]        out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, in_qh, in_tag, out_ready,
        input  in_ready, out_valid, out_c, out_tag, out_err
    );
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_qh, in_tag, out_ready,
        output in_ready, out_valid, out_c, out_tag, out_err
    );
endinterface

// File: rtl/modaddsub_pipe.sv
// Multi-lane pipelined modular add/sub, q = {qH, 0..0, 1}, with a global stall on out_ready.
// Defining MODADDSUB_RANGE_CHK_EN adds per-lane (A >= q || B >= q) flags on out_err.
module modaddsub_lane #(
    parameter int LOGQ   = 64,
    parameter int LOGQH  = 47,
    parameter int FF_IN  = 1,
    parameter int FF_MID = 1,
    parameter int FF_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             op,
    input  logic [LOGQH-1:0] qh,
    input  logic [LOGQ-1:0]  a,
    input  logic [LOGQ-1:0]  b,
    output logic [LOGQ-1:0]  c,
    output logic             err
);
    localparam int W = LOGQ - LOGQH;

    logic [LOGQ-1:0]  a0, b0, q0, c1;
    logic [LOGQH-1:0] qh0;
    logic             op0, op1, use_corr;
    logic [LOGQ:0]    raw0, raw1;
    logic [LOGQ+1:0]  corr0, corr1;
    logic             unused_corr_bit;

    if (FF_IN != 0) begin : g_in
        always_ff @(posedge clk) begin
            if (rst) begin
                a0 <= '0; b0 <= '0; op0 <= 1'b0; qh0 <= '0;
            end else if (en) begin
                a0 <= a; b0 <= b; op0 <= op; qh0 <= qh;
            end
        end
    end else begin : g_in_byp
        assign a0 = a;
        assign b0 = b;
        assign op0 = op;
        assign qh0 = qh;
    end

    assign q0 = {qh0, {(W-1){1'b0}}, 1'b1};
    // Both candidates are formed up front; the select only needs sign/borrow bits.
    assign raw0  = op0 ? ({1'b0, a0} - {1'b0, b0}) : ({1'b0, a0} + {1'b0, b0});
    assign corr0 = op0 ? ({1'b0, raw0} + {2'b0, q0}) : ({1'b0, raw0} - {2'b0, q0});

    if (FF_MID != 0) begin : g_mid
        always_ff @(posedge clk) begin
            if (rst) begin
                raw1 <= '0; corr1 <= '0; op1 <= 1'b0;
            end else if (en) begin
                raw1 <= raw0; corr1 <= corr0; op1 <= op0;
            end
        end
    end else begin : g_mid_byp
        assign raw1 = raw0;
        assign corr1 = corr0;
        assign op1 = op0;
    end

    // add: keep s-q unless negative; sub: add q back only on borrow
    assign use_corr = op1 ? raw1[LOGQ] : !corr1[LOGQ+1];
    assign c1 = use_corr ? corr1[LOGQ-1:0] : raw1[LOGQ-1:0];
    assign unused_corr_bit = corr1[LOGQ];

    if (FF_OUT != 0) begin : g_out
        always_ff @(posedge clk) begin
            if (rst)     c <= '0;
            else if (en) c <= c1;
        end
    end else begin : g_out_byp
        assign c = c1;
    end

`ifdef MODADDSUB_RANGE_CHK_EN
    logic err0, err1;
    assign err0 = (a0 >= q0) || (b0 >= q0);
    if (FF_MID != 0) begin : g_err_mid
        always_ff @(posedge clk) begin
            if (rst)     err1 <= 1'b0;
            else if (en) err1 <= err0;
        end
    end else begin : g_err_mid_byp
        assign err1 = err0;
    end
    if (FF_OUT != 0) begin : g_err_out
        always_ff @(posedge clk) begin
            if (rst)     err <= 1'b0;
            else if (en) err <= err1;
        end
    end else begin : g_err_out_byp
        assign err = err1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

module modaddsub_pipe #(
    parameter int LANES  = 4,
    parameter int LOGQ   = 64,
    parameter int LOGQH  = 47,
    parameter int TAGW   = 8,
    parameter int FF_IN  = 1,
    parameter int FF_MID = 1,
    parameter int FF_OUT = 1
) (
    input  logic        clk,
    input  logic        rst,
    modaddsub_if.slave  bus
);
    localparam int LAT = FF_IN + FF_MID + FF_OUT;

    if (LOGQ - LOGQH < 2) begin : g_bad_w
        $error("modaddsub_pipe: LOGQ-LOGQH must be >= 2");
    end

    logic                       en;
    logic [LAT:0]               vld_pipe;
    logic [LAT:0][TAGW-1:0]     tag_pipe;
    logic [LANES-1:0][LOGQ-1:0] c_lane;
    logic [LANES-1:0]           err_lane;

    assign vld_pipe[0]   = bus.in_valid;
    assign tag_pipe[0]   = bus.in_tag;
    assign bus.out_valid = vld_pipe[LAT];
    assign bus.out_tag   = tag_pipe[LAT];
    assign bus.out_c     = c_lane;
    assign bus.out_err   = err_lane;

    if (LAT == 0) begin : g_comb
        assign en           = 1'b1;
        assign bus.in_ready = bus.out_ready;
    end else begin : g_pipe
        logic                     stall;
        logic [LAT:1]             vld_q;
        logic [LAT:1][TAGW-1:0]   tag_q;

        // Reset forces ready high so an asserted rst never looks like backpressure.
        assign stall        = bus.out_valid && !bus.out_ready && !rst;
        assign en           = !stall;
        assign bus.in_ready = !stall;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
                tag_q <= '0;
            end else if (en) begin
                vld_q <= vld_pipe[LAT-1:0];
                tag_q <= tag_pipe[LAT-1:0];
            end
        end
        assign vld_pipe[LAT:1] = vld_q;
        assign tag_pipe[LAT:1] = tag_q;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        modaddsub_lane #(
            .LOGQ(LOGQ), .LOGQH(LOGQH), .FF_IN(FF_IN), .FF_MID(FF_MID), .FF_OUT(FF_OUT)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .op  (bus.in_op),
            .qh  (bus.in_qh),
            .a   (bus.in_a[i*LOGQ +: LOGQ]),
            .b   (bus.in_b[i*LOGQ +: LOGQ]),
            .c   (c_lane[i]),
            .err (err_lane[i])
        );
    end
endmodule

// File: tb/tb_modaddsub_pipe.sv
// Bench for modaddsub_pipe (2 lanes x 8 bit, qH 4 bit, LAT 3) against a modulo-arithmetic model.
module tb_modaddsub_pipe;
    localparam int LANES = 2, LOGQ = 8, LOGQH = 4, TAGW = 4, LAT = 3;

    typedef struct { logic [15:0] c; logic [3:0] tag; logic [1:0] err; } exp_t;
    typedef struct { bit op; logic [3:0] qh; logic [7:0] a0, b0, a1, b1, c0, c1; } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    logic [3:0] next_tag = 4'h0;

    modaddsub_if #(.LANES(LANES), .LOGQ(LOGQ), .LOGQH(LOGQH), .TAGW(TAGW)) bus ();
    modaddsub_pipe #(
        .LANES(LANES), .LOGQ(LOGQ), .LOGQH(LOGQH), .TAGW(TAGW),
        .FF_IN(1), .FF_MID(1), .FF_OUT(1)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic int qval(input int qh);
        return qh * 16 + 1;
    endfunction

    function automatic logic [7:0] ref_lane(input bit op, input int a, input int b, input int qh);
        int q;
        q = qval(qh);
        if (op) return 8'((a - b + q) % q);
        return 8'((a + b) % q);
    endfunction

    function automatic logic ref_err(input int a, input int b, input int qh);
`ifdef MODADDSUB_RANGE_CHK_EN
        return (a >= qval(qh)) || (b >= qval(qh));
`else
        return 1'b0;
`endif
    endfunction

    // Feeds n random in-range transactions, logging what the model expects on acceptance.
    task automatic drive_stream(input int n, input bit alt, input bit gaps);
        bit op; int qh, q, a0, b0, a1, b1, guard;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            op = alt ? (i % 2 == 1) : bit'($urandom_range(0, 1));
            qh = $urandom_range(0, 15);
            q  = qval(qh);
            a0 = $urandom_range(0, q - 1); b0 = $urandom_range(0, q - 1);
            a1 = $urandom_range(0, q - 1); b1 = $urandom_range(0, q - 1);
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(negedge clk); bus.in_valid = 1'b0;
            end
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_op = op; bus.in_qh = 4'(qh); bus.in_tag = next_tag;
            bus.in_a = {8'(a1), 8'(a0)}; bus.in_b = {8'(b1), 8'(b0)};
            #1;
            guard = 0;
            while (!bus.in_ready && guard < 200) begin
                @(negedge clk); #1; guard++;
            end
            e.c   = {ref_lane(op, a1, b1, qh), ref_lane(op, a0, b0, qh)};
            e.tag = next_tag;
            e.err = {ref_err(a1, b1, qh), ref_err(a0, b0, qh)};
            exp_q.push_back(e);
            next_tag++;
        end
        @(negedge clk); bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        int seen = 0;
        rst = 1'b1; bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.in_a = 16'h1234; bus.in_b = 16'h0101; bus.in_qh = 4'hC; bus.in_tag = 4'h9; bus.in_op = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_c !== 16'h0) begin errors++; $display("FAIL reset_c: got %h want 0000", bus.out_c); end
        checks++; if (bus.out_tag !== 4'h0) begin errors++; $display("FAIL reset_tag: got %h want 0", bus.out_tag); end
        checks++; if (bus.out_err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", bus.out_err); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
        @(negedge clk); rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (5) begin @(negedge clk); #1; if (bus.out_valid) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL reset_drop: got %0d outputs want 0", seen); end
    endtask

    task automatic test_directed();
        vec_t v[8];
        v = '{'{1'b1, 4'hC, 8'd5,   8'd10,  8'd0,   8'd0,   8'd188, 8'd0},
              '{1'b0, 4'hC, 8'd150, 8'd100, 8'd192, 8'd0,   8'd57,  8'd192},
              '{1'b0, 4'hC, 8'd192, 8'd192, 8'd7,   8'd0,   8'd191, 8'd7},
              '{1'b1, 4'hC, 8'd0,   8'd192, 8'd77,  8'd77,  8'd1,   8'd0},
              '{1'b0, 4'h5, 8'd80,  8'd80,  8'd40,  8'd41,  8'd79,  8'd0},
              '{1'b1, 4'h5, 8'd3,   8'd70,  8'd0,   8'd80,  8'd14,  8'd1},
              '{1'b0, 4'hF, 8'd240, 8'd1,   8'd123, 8'd0,   8'd0,   8'd123},
              '{1'b1, 4'hF, 8'd240, 8'd0,   8'd17,  8'd17,  8'd240, 8'd0}};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_op = v[i].op; bus.in_qh = v[i].qh; bus.in_tag = 4'(i + 3);
            bus.in_a = {v[i].a1, v[i].a0}; bus.in_b = {v[i].b1, v[i].b0};
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL dir_ready[%0d]: got %b want 1", i, bus.in_ready); end
            for (int k = 1; k <= LAT; k++) begin
                @(negedge clk); bus.in_valid = 1'b0; #1;
                checks++;
                if (k < LAT) begin
                    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dir_early[%0d]: valid %b at cycle %0d want 0", i, bus.out_valid, k); end
                end else if (bus.out_valid !== 1'b1 || bus.out_c !== {v[i].c1, v[i].c0} ||
                             bus.out_tag !== 4'(i + 3) || bus.out_err !== 2'b00) begin
                    errors++;
                    $display("FAIL dir_result[%0d]: valid=%b c=%h tag=%h err=%b want valid=1 c=%h tag=%h err=00",
                             i, bus.out_valid, bus.out_c, bus.out_tag, bus.out_err, {v[i].c1, v[i].c0}, 4'(i + 3));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int got = 0, cyc = 0, first = 0, last = 0;
        exp_t e;
        bus.out_ready = 1'b1;
        fork
            drive_stream(8, 1'b1, 1'b0);
            while (got < 8 && cyc < 100) begin
                @(negedge clk); #1; cyc++;
                if (bus.out_valid) begin
                    if (got == 0) first = cyc;
                    last = cyc;
                    e = exp_q.pop_front();
                    checks++;
                    if (bus.out_c !== e.c || bus.out_tag !== e.tag || bus.out_err !== e.err) begin
                        errors++;
                        $display("FAIL b2b_out: c=%h tag=%h err=%b want c=%h tag=%h err=%b",
                                 bus.out_c, bus.out_tag, bus.out_err, e.c, e.tag, e.err);
                    end
                    got++;
                end
            end
        join
        checks++;
        if (got != 8 || last - first != 7 || first != 1 + LAT) begin
            errors++;
            $display("FAIL b2b_timing: got %0d results first=%0d last=%0d want 8 results first=%0d last=%0d",
                     got, first, last, 1 + LAT, 8 + LAT);
        end
        exp_q.delete();
    endtask

    task automatic test_stall();
        int got = 0, cyc = 0, nstall = 0, k = 0;
        bit saw_first = 0, stalled = 0;
        logic [15:0] hold_c;
        logic [3:0]  hold_tag;
        exp_t e;
        bus.out_ready = 1'b1;
        fork
            drive_stream(6, 1'b0, 1'b0);
            begin
                while (got < 6 && cyc < 100) begin
                    @(negedge clk); #1; cyc++;
                    if (bus.out_valid && !bus.out_ready) begin
                        checks++;
                        if (bus.in_ready !== 1'b0 || (stalled && (bus.out_c !== hold_c || bus.out_tag !== hold_tag))) begin
                            errors++;
                            $display("FAIL stall_hold: ready=%b c=%h tag=%h want ready=0 c=%h tag=%h",
                                     bus.in_ready, bus.out_c, bus.out_tag, hold_c, hold_tag);
                        end
                        hold_c = bus.out_c; hold_tag = bus.out_tag; stalled = 1; nstall++;
                    end else if (bus.out_valid) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL stall_extra: tag=%h with nothing outstanding", bus.out_tag);
                        end else begin
                            e = exp_q.pop_front();
                            if (bus.out_c !== e.c || bus.out_tag !== e.tag || bus.out_err !== e.err) begin
                                errors++;
                                $display("FAIL stall_out: c=%h tag=%h err=%b want c=%h tag=%h err=%b",
                                         bus.out_c, bus.out_tag, bus.out_err, e.c, e.tag, e.err);
                            end
                        end
                        got++; saw_first = 1; stalled = 0;
                    end
                end
            end
            begin
                while (!saw_first && k < 50) begin @(negedge clk); k++; end
                bus.out_ready = 1'b0;
                repeat (3) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        checks++;
        if (got != 6 || nstall != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_count: got %0d results %0d stall cycles %0d left want 6 3 0", got, nstall, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        int got = 0, cyc = 0;
        bit done = 0;
        exp_t e;
        fork
            drive_stream(40, 1'b0, 1'b1);
            begin
                while (got < 40 && cyc < 2000) begin
                    @(negedge clk); #1; cyc++;
                    if (bus.out_valid && bus.out_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL rand_extra: tag=%h with nothing outstanding", bus.out_tag);
                        end else begin
                            e = exp_q.pop_front();
                            if (bus.out_c !== e.c || bus.out_tag !== e.tag || bus.out_err !== e.err) begin
                                errors++;
                                $display("FAIL rand_out: c=%h tag=%h err=%b want c=%h tag=%h err=%b",
                                         bus.out_c, bus.out_tag, bus.out_err, e.c, e.tag, e.err);
                            end
                        end
                        got++;
                    end
                end
                done = 1;
            end
            while (!done) begin
                @(negedge clk); bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        bus.out_ready = 1'b1;
        checks++;
        if (got != 40 || exp_q.size() != 0) begin
            errors++; $display("FAIL rand_count: got %0d results %0d left want 40 0", got, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_rst_mid();
        int seen = 0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_op = 1'b0; bus.in_qh = 4'hC; bus.in_tag = 4'(10 + k);
            bus.in_a = {8'(k), 8'(20 + k)}; bus.in_b = 16'h0101;
        end
        @(negedge clk); bus.in_valid = 1'b0; rst = 1'b1; #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_inflight: valid %b want 1", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.in_ready); end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_c !== 16'h0 || bus.out_tag !== 4'h0) begin
            errors++; $display("FAIL rst_clear: valid=%b c=%h tag=%h want 0 0000 0", bus.out_valid, bus.out_c, bus.out_tag);
        end
        bus.out_ready = 1'b1;
        repeat (10) begin @(negedge clk); #1; if (bus.out_valid) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_reemit: got %0d outputs want 0", seen); end
    endtask

`ifdef MODADDSUB_RANGE_CHK_EN
    task automatic test_range();
        logic [7:0] a0[2], b0[2], a1[2], b1[2], c_chk[2];
        logic [1:0] err_exp[2];
        bit         op[2];
        a0 = '{8'hC1, 8'd5}; b0 = '{8'h00, 8'd3}; a1 = '{8'h10, 8'h00}; b1 = '{8'h20, 8'hC1};
        op = '{1'b0, 1'b1}; err_exp = '{2'b01, 2'b10}; c_chk = '{8'h30, 8'h02};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_op = op[i]; bus.in_qh = 4'hC; bus.in_tag = 4'h7;
            bus.in_a = {a1[i], a0[i]}; bus.in_b = {b1[i], b0[i]};
            @(negedge clk); bus.in_valid = 1'b0;
            repeat (LAT - 1) @(negedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_err !== err_exp[i] ||
                (i == 0 ? bus.out_c[15:8] : bus.out_c[7:0]) !== c_chk[i]) begin
                errors++;
                $display("FAIL range[%0d]: valid=%b err=%b c=%h want valid=1 err=%b good-lane c=%h",
                         i, bus.out_valid, bus.out_err, bus.out_c, err_exp[i], c_chk[i]);
            end
        end
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0; bus.in_op = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.in_qh = '0; bus.in_tag = '0; bus.out_ready = 1'b0; rst = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random();
        test_rst_mid();
`ifdef MODADDSUB_RANGE_CHK_EN
        test_range();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
